mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port op, input, 6 bits: instruction opcode field from the instruction register, stable from DECODE onward.
REQ-004 The block SHALL have port funct, input, 6 bits: instruction function field from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag for the current ALU operation.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-007 The block SHALL have ports pc_write, ir_write, reg_write, mem_read and mem_write, each output, 1 bit: datapath write/read strobes.
REQ-008 The block SHALL have port ext_op, output, 2 bits: immediate extender mode, using `EXT_ZERO / `EXT_SIGNED / `EXT_HIGHPOS from ctrl_encode_def.v.
REQ-009 The block SHALL have port alu_ctrl, output, 3 bits, encoded ADD=000, SUB=001, AND=010, OR=011, SLT=100.
REQ-010 The block SHALL have port alu_src_a, output, 1 bit: 0 selects PC, 1 selects rs.
REQ-011 The block SHALL have port alu_src_b, output, 2 bits: 00 rt, 01 constant 4, 10 extended immediate, 11 extended immediate<<2.
REQ-012 The block SHALL have ports reg_dst, output, 1 bit (0 rt, 1 rd) and wd_sel, output, 1 bit (0 ALUOut, 1 MDR).
REQ-013 The block SHALL have port pc_src, output, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 The block SHALL have ports illegal, output, 1 bit (one-cycle pulse), state, output, 4 bits (debug), and retired, output, 32 bits (retired-instruction count).

Function
REQ-015 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9. Codes 10-15 SHALL return to FETCH on the next edge.
REQ-016 Outputs SHALL be Moore-decoded from the state, with these exceptions: op/funct in EXEC/ALUWB/MEMADR, mem_ready in FETCH/MEMRD/MEMWR, and zero in BRANCH. Any strobe not listed for a state SHALL be 0.
REQ-017 FETCH SHALL drive: mem_read=1, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
REQ-018 FETCH SHALL assert pc_write=ir_write=mem_ready, hold while mem_ready=0, and go to DECODE when mem_ready=1.
REQ-019 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_ctrl=ADD, ext_op=`EXT_SIGNED (branch target precompute).
REQ-020 DECODE next state SHALL be: lw 100011 / sw 101011 -> MEMADR; R-type 000000, addi 001000, ori 001101, lui 001111 -> EXEC; beq 000100 -> BRANCH; j 000010 -> JUMP.
REQ-021 Any other op in DECODE SHALL pulse illegal=1 for one cycle and go to FETCH, with no increment of retired.
REQ-022 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, ext_op=`EXT_SIGNED, alu_ctrl=ADD, and go to MEMRD (lw) or MEMWR (sw).
REQ-023 MEMRD SHALL drive mem_read=1, hold until mem_ready=1, then go to MEMWB.
REQ-024 MEMWB SHALL drive reg_write=1, reg_dst=0, wd_sel=1, then go to FETCH.
REQ-025 MEMWR SHALL drive mem_write=1, hold until mem_ready=1, then go to FETCH.
REQ-026 EXEC SHALL drive alu_src_a=1 and then go to ALUWB.
REQ-027 EXEC for R-type SHALL drive alu_src_b=00 and alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-028 An undefined funct in EXEC SHALL pulse illegal and go to FETCH.
REQ-029 EXEC for immediates SHALL drive alu_src_b=10 with: addi -> ext_op=`EXT_SIGNED, ADD; ori -> `EXT_ZERO, OR; lui -> `EXT_HIGHPOS, OR (rs=$0).
REQ-030 ALUWB SHALL drive reg_write=1, wd_sel=0, reg_dst=1 for R-type and 0 otherwise, with ext_op and alu_ctrl held as in EXEC; then go to FETCH.
REQ-031 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01, pc_write=zero, then go to FETCH.
REQ-032 JUMP SHALL drive pc_src=10, pc_write=1, then go to FETCH.
REQ-033 retired SHALL increment by 1 on the edge leaving MEMWB, ALUWB, BRANCH or JUMP, and on the edge leaving MEMWR when mem_ready=1; it SHALL wrap 0xFFFFFFFF -> 0.
REQ-034 When an output's value is not defined for a state, ext_op SHALL be `EXT_SIGNED and alu_ctrl SHALL be ADD.
REQ-035 Latencies SHALL be, with mem_ready=1 throughout: R/imm 4 cycles, lw 5, sw 4, beq 3, j 3.

Reset
REQ-036 On a clk edge with rstn=0, state SHALL become FETCH, retired SHALL become 0, and illegal SHALL become 0, overriding any in-flight instruction including a held MEMWR/MEMRD.
REQ-037 During and after reset, outputs SHALL equal the FETCH decode: mem_read=1, pc_write=ir_write=mem_ready, all other strobes 0.

Verification
REQ-038 The bench SHALL check: reset mid-MEMWR with mem_ready=0 -> next cycle state=0, mem_write=0, retired=0.
REQ-039 The bench SHALL check: lw (op 100011), mem_ready=1 -> states 0,1,2,3,4; reg_write=1, wd_sel=1 only in state 4; retired=1.
REQ-040 The bench SHALL check: lui (op 001111) -> ext_op=`EXT_HIGHPOS, alu_ctrl=011, alu_src_b=10 in states 6/7; reg_dst=0.
REQ-041 The bench SHALL check: beq with zero=0, then with zero=1 -> pc_write=0, then pc_write=1 in state 8 with pc_src=01.
REQ-042 The bench SHALL check: FETCH with mem_ready low 3 cycles -> state stays 0, ir_write=0 for 3 cycles, then 1 on the 4th.
REQ-043 The bench SHALL check: op 111111, then R-type funct 000001 -> illegal pulses once each, state returns to 0, retired unchanged.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, strobes and mux selects out.
// The master side is the datapath (or bench); the slave side is mc_ctrl.
interface mc_ctrl_if;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic        ir_write;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  ext_op;
   logic [2:0]  alu_ctrl;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        reg_dst;
   logic        wd_sel;
   logic [1:0]  pc_src;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;

   modport master (
      output op, funct, zero, mem_ready,
      input  pc_write, ir_write, reg_write, mem_read, mem_write, ext_op, alu_ctrl,
             alu_src_a, alu_src_b, reg_dst, wd_sel, pc_src, illegal, state, retired
   );

   modport slave (
      input  op, funct, zero, mem_ready,
      output pc_write, ir_write, reg_write, mem_read, mem_write, ext_op, alu_ctrl,
             alu_src_a, alu_src_b, reg_dst, wd_sel, pc_src, illegal, state, retired
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute, decodes datapath
// controls from the state, and counts retired instructions.
module mc_ctrl (
   input logic      clk,
   input logic      rstn,
   mc_ctrl_if.slave bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] EXT_ZERO    = 2'b00;
   localparam logic [1:0] EXT_SIGNED  = 2'b01;
   localparam logic [1:0] EXT_HIGHPOS = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
      S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_ALUWB  = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9
   } state_t;

   state_t      r_state;
   logic [31:0] r_retired;
   logic        r_illegal;

   logic        w_rtype;
   logic        w_funct_ok;
   logic [2:0]  w_funct_alu;
   state_t      w_dec_state;

   logic        w_pc_write, w_ir_write, w_reg_write, w_mem_read, w_mem_write;
   logic [1:0]  w_ext_op, w_alu_src_b, w_pc_src;
   logic [2:0]  w_alu_ctrl;
   logic        w_alu_src_a, w_reg_dst, w_wd_sel;

   assign w_rtype = (bus.op == OP_RTYPE);

   // R-type function field to ALU operation; unknown codes fall back to ADD
   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = ALU_ADD;
      case (bus.funct)
         F_ADD:   w_funct_alu = ALU_ADD;
         F_SUB:   w_funct_alu = ALU_SUB;
         F_AND:   w_funct_alu = ALU_AND;
         F_OR:    w_funct_alu = ALU_OR;
         F_SLT:   w_funct_alu = ALU_SLT;
         default: w_funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_FETCH;
         r_retired <= 32'd0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (bus.op)
                  OP_LW, OP_SW:                       r_state <= S_MEMADR;
                  OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI:  r_state <= S_EXEC;
                  OP_BEQ:                             r_state <= S_BRANCH;
                  OP_J:                               r_state <= S_JUMP;
                  default: begin
                     r_illegal <= 1'b1;
                     r_state   <= S_FETCH;
                  end
               endcase
            end
            S_MEMADR: r_state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
            S_MEMWR: begin
               if (bus.mem_ready) begin
                  r_state   <= S_FETCH;
                  r_retired <= r_retired + 32'd1;
               end
            end
            S_EXEC: begin
               if (w_rtype && !w_funct_ok) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_FETCH;
               end else begin
                  r_state   <= S_ALUWB;
               end
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
               r_state   <= S_FETCH;
               r_retired <= r_retired + 32'd1;
            end
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // While reset is held the controls already present the FETCH decode
   assign w_dec_state = rstn ? r_state : S_FETCH;

   always_comb begin
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_ext_op    = EXT_SIGNED;
      w_alu_ctrl  = ALU_ADD;
      w_alu_src_a = 1'b0;
      w_alu_src_b = 2'b00;
      w_reg_dst   = 1'b0;
      w_wd_sel    = 1'b0;
      w_pc_src    = 2'b00;
      case (w_dec_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_pc_write  = bus.mem_ready;
            w_ir_write  = bus.mem_ready;
            w_alu_src_b = 2'b01;
         end
         S_DECODE: w_alu_src_b = 2'b11;
         S_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
         end
         S_MEMRD:  w_mem_read  = 1'b1;
         S_MEMWB: begin
            w_reg_write = 1'b1;
            w_wd_sel    = 1'b1;
         end
         S_MEMWR:  w_mem_write = 1'b1;
         S_EXEC, S_ALUWB: begin
            w_alu_src_a = 1'b1;
            if (w_rtype) begin
               w_alu_src_b = 2'b00;
               w_alu_ctrl  = w_funct_alu;
            end else begin
               w_alu_src_b = 2'b10;
               case (bus.op)
                  OP_ORI: begin
                     w_ext_op   = EXT_ZERO;
                     w_alu_ctrl = ALU_OR;
                  end
                  OP_LUI: begin
                     w_ext_op   = EXT_HIGHPOS;
                     w_alu_ctrl = ALU_OR;
                  end
                  default: ;
               endcase
            end
            if (w_dec_state == S_ALUWB) begin
               w_reg_write = 1'b1;
               w_reg_dst   = w_rtype;
            end
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_ctrl  = ALU_SUB;
            w_pc_src    = 2'b01;
            w_pc_write  = bus.zero;
         end
         S_JUMP: begin
            w_pc_src   = 2'b10;
            w_pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.pc_write  = w_pc_write;
   assign bus.ir_write  = w_ir_write;
   assign bus.reg_write = w_reg_write;
   assign bus.mem_read  = w_mem_read;
   assign bus.mem_write = w_mem_write;
   assign bus.ext_op    = w_ext_op;
   assign bus.alu_ctrl  = w_alu_ctrl;
   assign bus.alu_src_a = w_alu_src_a;
   assign bus.alu_src_b = w_alu_src_b;
   assign bus.reg_dst   = w_reg_dst;
   assign bus.wd_sel    = w_wd_sel;
   assign bus.pc_src    = w_pc_src;
   assign bus.illegal   = r_illegal;
   assign bus.state     = r_state;
   assign bus.retired   = r_retired;
endmodule
